// File: rtl/text_tile_fetcher.sv
// text_tile_fetcher: walks the character cells of a scanline, fetches
// code then glyph row, and serialises each glyph row MSB-first.
module text_tile_fetcher #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int FONT_BASE = 2400,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [8:0]        line,
  input  logic              de,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              pixel,
  output logic              pixel_valid
);

  localparam int CW = $clog2(COLS + 1);
  localparam logic [9:0] LINES = 10'(ROWS * 8);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] FBASE = ADDR_W'(FONT_BASE);
  localparam logic [CW-1:0] COLS_C = CW'(COLS);

  if (FONT_BASE + 2047 >= (1 << ADDR_W)) begin : g_cfg_chk
    $error("font region does not fit in memory");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PF_CODE,
    S_PF_GLYPH,
    S_ACTIVE,
    S_DONE,
    S_BLANK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [5:0]        text_row;
  logic [2:0]        glyph_row;
  logic [CW-1:0]     col;
  logic [CW-1:0]     col_nxt;
  logic [2:0]        phase;
  logic [7:0]        shift;
  logic [7:0]        next_glyph;
  logic              pf_valid;
  logic              line_ok;
  logic              adv;
  logic              ph0;
  logic              fetch_char;
  logic              fetch_font;
  logic              cap_glyph;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] char_addr;
  logic [ADDR_W-1:0] font_addr;

  assign line_ok    = {1'b0, line} < LINES;
  assign col_nxt    = col + 1'b1;
  assign start_addr = ADDR_W'(line[8:3]) * COLS_A;
  assign char_addr  = ADDR_W'(text_row) * COLS_A
                    + ADDR_W'(col_nxt);
  assign font_addr  = FBASE
                    + ADDR_W'({mem_data, 3'b000})
                    + ADDR_W'(glyph_row);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = line_ok ? S_PF_CODE : S_BLANK;
    end else begin
      unique case (state)
        S_PF_CODE:  state_nxt = S_PF_GLYPH;
        S_PF_GLYPH: state_nxt = S_ACTIVE;
        S_ACTIVE:
          if (adv && phase == 3'd7 && col == COLS_C)
            state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  // col already points at the cell being fetched, one ahead of display
  always_comb begin
    adv        = (state == S_ACTIVE) && de && !line_start;
    ph0        = adv && (phase == 3'd0);
    fetch_char = ph0 && (col_nxt < COLS_C);
    fetch_font = !line_start
               && ((state == S_PF_CODE)
               || (adv && phase == 3'd1 && col < COLS_C));
    cap_glyph  = !line_start
               && ((state == S_PF_GLYPH)
               || (adv && phase == 3'd2 && col < COLS_C));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr    <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      text_row    <= '0;
      glyph_row   <= '0;
      col         <= '0;
      phase       <= '0;
      shift       <= '0;
      next_glyph  <= '0;
      pf_valid    <= 1'b0;
    end else begin
      pixel_valid <= de;
      pixel       <= 1'b0;
      if (line_start) begin
        text_row   <= line[8:3];
        glyph_row  <= line[2:0];
        col        <= '0;
        phase      <= '0;
        shift      <= '0;
        next_glyph <= '0;
        pf_valid   <= 1'b0;
        if (line_ok) mem_addr <= start_addr;
      end else begin
        if (fetch_char)      mem_addr <= char_addr;
        else if (fetch_font) mem_addr <= font_addr;
        if (cap_glyph) begin
          next_glyph <= mem_data;
          pf_valid   <= 1'b1;
        end
        if (adv) begin
          phase <= phase + 3'd1;
          pixel <= ph0 ? (pf_valid & next_glyph[7])
                       : shift[7];
          shift <= ph0 ? {next_glyph[6:0], 1'b0}
                       : {shift[6:0], 1'b0};
        end
        if (ph0) begin
          col      <= col_nxt;
          pf_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_tile_fetcher.sv
// tb_text_tile_fetcher: scoreboard bench for the text tile fetcher,
// with a behavioural memory and reference pixel model.
module tb_text_tile_fetcher;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          line_start = 1'b0;
  logic [8:0]    line = '0;
  logic          de = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          pixel;
  logic          pixel_valid;

  logic [7:0] mem [0:(1<<AW)-1];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  text_tile_fetcher dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .line_start  (line_start),
    .line        (line),
    .de          (de),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic expq[$];

  bit ref_on = 0;
  int ref_ln = 0;
  int ref_k = 0;

  bit trk = 0;
  int maxc = 0;
  bit btrk = 0;
  bit bchg = 0;
  logic [AW-1:0] baddr = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic ref_pix(input int ln, input int k);
    logic [7:0] code;
    logic [7:0] g;
    if (k >= 640) return 1'b0;
    code = mem[(ln / 8) * 80 + k / 8];
    g = mem[2400 + int'(code) * 8 + ln % 8];
    return g[7 - k % 8];
  endfunction

  task automatic drive(input logic ls, input int ln,
                       input logic d);
    logic e;
    e = 1'b0;
    line_start = ls;
    line = 9'(ln);
    de = d;
    if (ls) begin
      ref_on = (ln < 240);
      ref_ln = ln;
      ref_k = 0;
    end else if (d && ref_on) begin
      e = ref_pix(ref_ln, ref_k);
      ref_k++;
    end
    if (d) expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset_n && pixel_valid) begin
      if (expq.size() == 0) chk("pv_extra", pixel_valid, 0);
      else chk("pix", pixel, expq.pop_front());
    end
    if (trk && mem_addr < 2400 && int'(mem_addr) > maxc)
      maxc = int'(mem_addr);
    if (btrk && mem_addr !== baddr) bchg = 1;
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = (i < 2400) ? 8'(i * 13 + 7)
                          : 8'((i * 29) ^ (i >> 4));
    mem[0] = 8'h41;
    mem[2400 + 8'h41 * 8] = 8'h18;

    #2;
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", pixel, 0);
    chk("rst_pv", pixel_valid, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // line 0: first cell is 'A' with glyph row 0x18
    maxc = 0;
    trk = 1;
    drive(1'b1, 0, 1'b0);
    chk("b_char", mem_addr, 0);
    drive(1'b0, 0, 1'b0);
    chk("b_font", mem_addr, 2920);
    idle(2);
    run(648);
    idle(2);
    trk = 0;
    chk("b_maxc", maxc, 79);

    // line 13 with a mid-cell de gap
    maxc = 0;
    trk = 1;
    drive(1'b1, 13, 1'b0);
    chk("r13_char", mem_addr, 80);
    drive(1'b0, 0, 1'b0);
    chk("r13_font", mem_addr, 2400 + int'(mem[80]) * 8 + 5);
    idle(2);
    run(333);
    idle(5);
    run(315);
    idle(2);
    trk = 0;
    chk("r13_maxc", maxc, 159);

    // blank line
    drive(1'b1, 240, 1'b0);
    baddr = mem_addr;
    bchg = 0;
    btrk = 1;
    idle(3);
    run(640);
    idle(2);
    btrk = 0;
    chk("blank_hold", bchg, 0);

    // restart in cell 10 of line 0
    drive(1'b1, 0, 1'b0);
    idle(3);
    run(84);
    drive(1'b1, 8, 1'b1);
    chk("rs_char", mem_addr, 80);
    idle(3);
    run(648);
    idle(2);

    // async reset mid-line with de high
    drive(1'b1, 16, 1'b0);
    idle(3);
    run(100);
    reset_n = 1'b0;
    #1;
    chk("mr_addr", mem_addr, 0);
    chk("mr_pix", pixel, 0);
    chk("mr_pv", pixel_valid, 0);
    expq.delete();
    ref_on = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(20);
    chk("mr_idle_addr", mem_addr, 0);
    idle(2);
    drive(1'b1, 17, 1'b0);
    idle(3);
    run(648);
    idle(3);

    chk("drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
